// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch - instruction fetch stage for the teaching CPU.
//
// Owns the program counter and drives the word address of an asynchronous
// instruction ROM. The returned word is captured into an IF/ID holding
// register and offered to decode over a valid/ready handshake. Decode can
// redirect fetch with a branch/jump; a misaligned target halts the stage
// until reset.
//
// Optional feature macro: INST_FETCH_PERF_CNT_EN
//   defined   -> fetch_cnt port present, counts accepted instructions
//   undefined -> fetch_cnt port and counter absent
//
// Ports:
//   clk        in   system clock, rising edge
//   resetn     in   asynchronous active-low reset
//   fetch_en   in   level, allows fetching to start or continue
//   inst_addr  out  ROM word address, combinational from pc
//   inst       in   ROM data for inst_addr, same cycle
//   id_valid   out  IF/ID register holds an instruction
//   id_ready   in   decode accepts id_inst this cycle
//   id_inst    out  buffered instruction
//   id_pc      out  byte address of id_inst
//   br_taken   in   redirect request pulse
//   br_target  in   redirect byte address
//   fetch_err  out  sticky misaligned-target flag
//   fetch_cnt  out  accepted-instruction count (macro only)
// -----------------------------------------------------------------------------
module inst_fetch #(
  parameter int unsigned ADDR_W   = 5,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic [31:0]       inst,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [31:0]       id_inst,
  output logic [31:0]       id_pc,
  input  logic              br_taken,
  input  logic [31:0]       br_target,
  output logic              fetch_err
`ifdef INST_FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_cnt
`endif
);

  localparam int unsigned PC_W = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic [31:0]     r_id_inst;
  logic [PC_W-1:0] r_id_pc;
  logic            r_id_valid;
  logic            r_fetch_err;

  logic            w_load;
  logic            w_accept;
  logic            w_tgt_aligned;

  // Holding register may be refilled when empty or being drained this cycle.
  assign w_load        = !r_id_valid || id_ready;
  assign w_accept      = r_id_valid && id_ready;
  assign w_tgt_aligned = (br_target[1:0] == 2'b00);

  // ROM address is the word index of pc; upper pc bits alias.
  assign inst_addr = r_pc[ADDR_W+1:2];

  assign id_valid  = r_id_valid;
  assign id_inst   = r_id_inst;
  assign id_pc     = r_id_pc;
  assign fetch_err = r_fetch_err;

  // Fetch state machine, pc and IF/ID register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_id_inst   <= 32'd0;
      r_id_pc     <= 32'd0;
      r_id_valid  <= 1'b0;
      r_fetch_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (br_taken && !w_tgt_aligned) begin
            r_fetch_err <= 1'b1;
            r_id_valid  <= 1'b0;
            r_state     <= S_HALT;
          end else begin
            if (br_taken) begin
              r_pc       <= br_target;
              r_id_valid <= 1'b0;
            end
            if (fetch_en) begin
              r_state <= S_RUN;
            end
          end
        end

        S_RUN: begin
          // Redirect wins over load: the in-flight word at pc is wrong-path.
          if (br_taken) begin
            r_id_valid <= 1'b0;
            if (w_tgt_aligned) begin
              r_pc <= br_target;
            end else begin
              r_fetch_err <= 1'b1;
              r_state     <= S_HALT;
            end
          end else if (w_load) begin
            if (fetch_en) begin
              r_id_inst  <= inst;
              r_id_pc    <= r_pc;
              r_id_valid <= 1'b1;
              r_pc       <= r_pc + PC_W'(4);
            end else begin
              // Current entry is drained; stop with pc pointing at next fetch.
              r_id_valid <= 1'b0;
              r_state    <= S_IDLE;
            end
          end
        end

        S_HALT: begin
          r_id_valid <= 1'b0;
        end

        default: begin
          r_state    <= S_IDLE;
          r_id_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef INST_FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;

  // Counts handshakes; naturally frozen in HALT since id_valid is low there.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_fetch_cnt <= 32'd0;
    end else if (w_accept && (r_state != S_HALT)) begin
      r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end
  end

  assign fetch_cnt = r_fetch_cnt;
`else
  // Handshake only feeds the counter; keep it referenced without the feature.
  logic w_accept_unused;
  assign w_accept_unused = w_accept;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch - self-checking bench for inst_fetch.
// Table of per-cycle vectors for first fetch, stall and taken branch, then
// hand-written sequences for jump/wrap, misaligned halt and reset mid-stall.
// Accepted instructions are checked against an in-order expectation queue.
// -----------------------------------------------------------------------------
module tb_inst_fetch;
  localparam int unsigned ADDR_W = 5;

  logic              clk = 1'b0;
  logic              resetn;
  logic              fetch_en;
  logic [ADDR_W-1:0] inst_addr;
  logic [31:0]       inst;
  logic              id_valid;
  logic              id_ready;
  logic [31:0]       id_inst;
  logic [31:0]       id_pc;
  logic              br_taken;
  logic [31:0]       br_target;
  logic              fetch_err;
`ifdef INST_FETCH_PERF_CNT_EN
  logic [31:0]       fetch_cnt;
`endif

  inst_fetch #(.ADDR_W(ADDR_W), .RESET_PC(32'h0000_0000)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .fetch_en  (fetch_en),
    .inst_addr (inst_addr),
    .inst      (inst),
    .id_valid  (id_valid),
    .id_ready  (id_ready),
    .id_inst   (id_inst),
    .id_pc     (id_pc),
    .br_taken  (br_taken),
    .br_target (br_target),
    .fetch_err (fetch_err)
`ifdef INST_FETCH_PERF_CNT_EN
    ,
    .fetch_cnt (fetch_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Asynchronous ROM: 23 populated words, zeros beyond.
  logic [31:0] rom [32];
  assign inst = rom[inst_addr];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic              fe;
    logic              rdy;
    logic              br;
    logic [31:0]       tgt;
    logic              v;
    logic [31:0]       pc;
    logic [31:0]       ins;
    logic [ADDR_W-1:0] addr;
  } vec_t;
  vec_t tbl[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rom_word(input logic [31:0] pc);
    return rom[pc[ADDR_W+1:2]];
  endfunction

  function automatic vec_t mk(input logic fe, input logic rdy, input logic br,
                              input logic [31:0] tgt, input logic v,
                              input logic [31:0] pc, input logic [31:0] ins,
                              input logic [ADDR_W-1:0] addr);
    vec_t r;
    r.fe = fe; r.rdy = rdy; r.br = br; r.tgt = tgt;
    r.v = v; r.pc = pc; r.ins = ins; r.addr = addr;
    return r;
  endfunction

  task automatic push(input logic [31:0] pc, input logic [31:0] ins);
    exp_t e;
    e.pc  = pc;
    e.ins = ins;
    sb_q.push_back(e);
  endtask

  // Apply inputs for one clock edge, then settle just past it.
  task automatic drive(input logic fe, input logic rdy, input logic br, input logic [31:0] tgt);
    fetch_en  = fe;
    id_ready  = rdy;
    br_taken  = br;
    br_target = tgt;
    @(posedge clk);
    #1;
  endtask

  // Every handshake must match the next expected instruction in order.
  always @(negedge clk) begin
    exp_t e;
    if (resetn === 1'b1 && id_valid === 1'b1 && id_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got accept of pc %h expected none", id_pc);
      end else begin
        e = sb_q.pop_front();
        chk("sb_pc", id_pc, e.pc);
        chk("sb_inst", id_inst, e.ins);
      end
    end
  end

  initial begin
    logic prev_v;

    for (int i = 0; i < 32; i++) rom[i] = (i <= 22) ? (32'hA000_0000 | 32'(i)) : 32'd0;
    rom[0]  = 32'h2401_0001;
    rom[1]  = 32'h0001_1100;
    rom[2]  = 32'h0041_1821;
    rom[13] = 32'h8C2A_0013;

    tbl[0] = mk(1, 1, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    tbl[1] = mk(1, 1, 0, 0, 1, 32'h0, 32'h2401_0001, 5'd1);
    tbl[2] = mk(1, 1, 0, 0, 1, 32'h4, 32'h0001_1100, 5'd2);
    for (int i = 3; i <= 5; i++) tbl[i] = mk(1, 0, 0, 0, 1, 32'h4, 32'h0001_1100, 5'd2);
    tbl[6] = mk(1, 1, 0, 0, 1, 32'h8, 32'h0041_1821, 5'd3);
    for (int i = 7; i <= 15; i++) begin
      logic [31:0] p;
      p = 32'h0C + 32'(4 * (i - 7));
      tbl[i] = mk(1, 1, 0, 0, 1, p, rom_word(p), ADDR_W'((p >> 2) + 1));
    end
    tbl[16] = mk(1, 1, 1, 32'h34, 0, 32'h0, 32'h0, 5'd13);
    tbl[17] = mk(1, 1, 0, 0, 1, 32'h34, 32'h8C2A_0013, 5'd14);
    tbl[18] = mk(1, 1, 0, 0, 1, 32'h38, rom_word(32'h38), 5'd15);

    resetn = 1'b0; fetch_en = 1'b0; id_ready = 1'b0; br_taken = 1'b0; br_target = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_inst", id_inst, 32'd0);
    chk("rst_pc", id_pc, 32'd0);
    chk("rst_err", 32'(fetch_err), 32'd0);
    chk("rst_addr", 32'(inst_addr), 32'd0);
`ifdef INST_FETCH_PERF_CNT_EN
    chk("rst_cnt", fetch_cnt, 32'd0);
`endif
    @(negedge clk);
    resetn = 1'b1;
    drive(0, 1, 0, 0);
    chk("idle_hold_valid", 32'(id_valid), 32'd0);

    // First fetch, stall and taken branch.
    prev_v = 1'b0;
    foreach (tbl[i]) begin
      if (tbl[i].v && (!prev_v || tbl[i].rdy)) push(tbl[i].pc, tbl[i].ins);
      drive(tbl[i].fe, tbl[i].rdy, tbl[i].br, tbl[i].tgt);
      chk($sformatf("row%0d_valid", i), 32'(id_valid), 32'(tbl[i].v));
      if (tbl[i].v) begin
        chk($sformatf("row%0d_pc", i), id_pc, tbl[i].pc);
        chk($sformatf("row%0d_inst", i), id_inst, tbl[i].ins);
      end
      chk($sformatf("row%0d_addr", i), 32'(inst_addr), 32'(tbl[i].addr));
      chk($sformatf("row%0d_err", i), 32'(fetch_err), 32'd0);
      prev_v = tbl[i].v;
    end

    // Jump back to 0 from 0x58, then run until pc 0x80 aliases word 0.
    for (int p = 32'h3C; p <= 32'h58; p += 4) begin
      push(32'(p), rom_word(32'(p)));
      drive(1, 1, 0, 0);
    end
    chk("jmp_pre_pc", id_pc, 32'h58);
    drive(1, 1, 1, 32'h0);
    chk("jmp_bubble", 32'(id_valid), 32'd0);
    chk("jmp_addr", 32'(inst_addr), 32'd0);
    push(32'h0, 32'h2401_0001);
    drive(1, 1, 0, 0);
    chk("jmp_pc", id_pc, 32'h0);
    chk("jmp_inst", id_inst, 32'h2401_0001);
    for (int p = 4; p <= 32'h80; p += 4) begin
      if (p == 32'h80) chk("alias_addr", 32'(inst_addr), 32'd0);
      push(32'(p), rom_word(32'(p)));
      drive(1, 1, 0, 0);
    end
    chk("alias_pc", id_pc, 32'h80);
    chk("alias_inst", id_inst, 32'h2401_0001);

    // Misaligned target halts until reset.
    drive(1, 1, 1, 32'h36);
    chk("mis_valid", 32'(id_valid), 32'd0);
    chk("mis_err", 32'(fetch_err), 32'd1);
    chk("mis_addr", 32'(inst_addr), 32'd1);
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, (i % 2) == 1, 32'h40);
      chk($sformatf("halt%0d_valid", i), 32'(id_valid), 32'd0);
      chk($sformatf("halt%0d_err", i), 32'(fetch_err), 32'd1);
      chk($sformatf("halt%0d_addr", i), 32'(inst_addr), 32'd1);
    end
    chk("halt_sb_empty", 32'(sb_q.size()), 32'd0);
    #2 resetn = 1'b0;
    #1;
    chk("halt_rst_err", 32'(fetch_err), 32'd0);
    chk("halt_rst_addr", 32'(inst_addr), 32'd0);

    // Accept five, stall, then asynchronous reset between edges.
    @(negedge clk);
    resetn = 1'b1;
    sb_q.delete();
    drive(1, 1, 0, 0);
    chk("cnt_idle_valid", 32'(id_valid), 32'd0);
    for (int k = 0; k < 6; k++) begin
      push(32'(4 * k), rom_word(32'(4 * k)));
      drive(1, 1, 0, 0);
    end
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    chk("stall_pc", id_pc, 32'h14);
    chk("stall_valid", 32'(id_valid), 32'd1);
`ifdef INST_FETCH_PERF_CNT_EN
    chk("cnt_five", fetch_cnt, 32'd5);
`endif
    #2 resetn = 1'b0;
    #1;
    chk("arst_valid", 32'(id_valid), 32'd0);
    chk("arst_pc", id_pc, 32'd0);
    chk("arst_inst", id_inst, 32'd0);
    chk("arst_addr", 32'(inst_addr), 32'd0);
`ifdef INST_FETCH_PERF_CNT_EN
    chk("arst_cnt", fetch_cnt, 32'd0);
`endif
    sb_q.delete();
    @(negedge clk);
    resetn = 1'b1;
    drive(1, 1, 0, 0);
    chk("refetch_idle", 32'(id_valid), 32'd0);
    push(32'h0, 32'h2401_0001);
    drive(1, 1, 0, 0);
    chk("refetch_valid", 32'(id_valid), 32'd1);
    chk("refetch_pc", id_pc, 32'h0);
    chk("refetch_inst", id_inst, 32'h2401_0001);
    drive(0, 1, 0, 0);
    chk("stop_valid", 32'(id_valid), 32'd0);
    chk("stop_addr", 32'(inst_addr), 32'd1);
`ifdef INST_FETCH_PERF_CNT_EN
    chk("stop_cnt", fetch_cnt, 32'd1);
`endif
    drive(0, 1, 0, 0);
    chk("stop_hold_addr", 32'(inst_addr), 32'd1);
    chk("end_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage for the teaching CPU. It owns the program counter and drives the word address of the asynchronous instruction ROM. It captures the returned instruction into an IF/ID holding register and hands it to decode over a valid/ready handshake. It also accepts branch and jump redirects from decode and stops on misaligned fetch targets.

## Interface
- ADDR_W, 5, ROM word-address width; `inst_addr` = pc[ADDR_W+1:2]
- RESET_PC, 32'h0000_0000, pc value loaded by reset
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset; the only clock is `clk`
- fetch_en  in  1  level; 1 allows fetching to start or continue
- inst_addr  out  ADDR_W  word address to ROM, combinational from pc
- inst  in  32  ROM data, valid in the same cycle as `inst_addr`
- id_valid  out  1  IF/ID register holds an instruction
- id_ready  in  1  decode accepts the instruction this cycle
- id_inst  out  32  buffered instruction
- id_pc  out  32  byte address of `id_inst`
- br_taken  in  1  redirect request, 1-cycle pulse from decode
- br_target  in  32  redirect byte address
- fetch_err  out  1  sticky misaligned-target flag
- fetch_cnt  out  32  accepted-instruction count (only with the macro)

## Operation
- **State machine:** IDLE, RUN, HALT.
- **Reset:** state=IDLE, pc=RESET_PC, id_valid=0, id_inst=0, id_pc=0, fetch_err=0, fetch_cnt=0.
- **IDLE:**
  - fetch_en=1 → RUN.
  - No capture happens in IDLE.
- **RUN:**
  - Load condition is load = !id_valid || id_ready.
  - On load: id_inst<=inst, id_pc<=pc, id_valid<=1, pc<=pc+4.
  - If !load, everything holds. This is the stall case.
  - fetch_en=0 with load: id_valid<=0 once the current entry has been accepted, then → IDLE. pc holds.
- **Redirect** (br_taken=1, any state except HALT; it has priority over load):
  - If br_target[1:0]=0: pc<=br_target, id_valid<=0. The wrong-path buffered and in-flight instructions are dropped. There is no delay slot.
  - If br_target[1:0]≠0: fetch_err<=1, id_valid<=0, → HALT. pc is left unchanged.
- **HALT:** outputs are frozen with id_valid=0. Only resetn exits HALT.
- **Arithmetic and wrap:**
  - pc is 32-bit and wraps modulo 2^32.
  - `inst_addr` truncates pc, so addresses beyond the ROM depth alias.
  - ROM returns 0 beyond its populated entries. 0 is latched as a normal instruction (sll $0 = nop).
- **Simultaneous events:** when br_taken and id_ready are both high, decode's acceptance of the current id_inst stands, but no new capture occurs that cycle.

## Timing
- inst_addr→inst→id_inst is a combinational path, captured on the same clock edge. Fetch latency is 1 cycle from pc to id_valid.
- Throughput is 1 instruction per cycle while id_ready=1.
- A redirect costs exactly one bubble: id_valid=0 in the cycle after br_taken, and the target instruction is valid the cycle after that.
- id_valid, id_inst and id_pc must stay stable while id_valid=1 and id_ready=0.
- resetn assertion mid-stall or mid-redirect clears state immediately, without waiting for a clock edge. Fetching resumes from RESET_PC on the first edge after deassertion with fetch_en=1, after one IDLE→RUN cycle.

## Configuration
- Macro: `INST_FETCH_PERF_CNT_EN`.
- **Defined:** `fetch_cnt` increments by 1 on each cycle with id_valid && id_ready. It wraps at 2^32, resets to 0, and freezes in HALT.
- **Undefined:** the `fetch_cnt` port and its counter are absent. All other behaviour is identical.

## Test plan
- **Reset and first fetch:** reset, then fetch_en=1, id_ready=1.
  - inst_addr=0.
  - Two cycles later id_valid=1, id_inst=32'h24010001, id_pc=0.
  - The next beat is id_inst=32'h00011100, id_pc=4.
- **Stall:** id_ready=0 for 3 cycles while holding id_pc=4.
  - id_inst stays 32'h00011100 and pc stays 8.
  - After id_ready returns to 1, the next id_pc=8 with id_inst=32'h00411821.
- **Taken branch:** br_taken=1 with br_target=32'h34 while id_pc=0x2C.
  - The next cycle has id_valid=0.
  - The following cycle has id_pc=0x34, id_inst=32'h8C2A0013.
  - The instruction at 0x30 is never presented.
- **Jump and wrap:** run to id_pc=0x58, then redirect to 0x00.
  - The stream restarts with 32'h24010001.
  - With redirect disabled, pc 0x80 aliases to inst_addr=0.
- **Misaligned target:** br_target=32'h36.
  - fetch_err=1, id_valid=0, and HALT persists for 10 cycles.
  - resetn low clears fetch_err=0.
- **Reset mid-stall plus counter (macro defined):** accept 5 instructions, then stall, then assert resetn low asynchronously between edges.
  - Before reset, fetch_cnt=5.
  - Outputs clear immediately: id_valid=0, fetch_cnt=0.
  - The refetch starts at id_pc=0.
